// File: rtl/message_datapath_pkg.sv
// Shared defaults and helpers for the message datapath and its controller, so
// character width, message length and hold time agree across the hierarchy.
package message_datapath_pkg;

  localparam int unsigned DefCharW      = 8;
  localparam int unsigned DefNumChars   = 4;
  localparam int unsigned DefHoldCycles = 3;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear and enable.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   clr  synchronous clear, wins over en
//   en   count enable; wraps to 0 from N-1
//   q    current count
//   tc   terminal count (q == N-1)
module mod_counter
  import message_datapath_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  output logic [cnt_width(N)-1:0] q,
  output logic                    tc
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q == Last) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = (q_q == Last);

endmodule

// File: rtl/message_datapath.sv
// Message datapath: holds a NUM_CHARS x CHAR_W message and presents one
// character at a time, with a per-character hold counter and a character index.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   ld        load msg_in, clear counters, set active
//   cnt1      advance hold counter
//   shift     advance to next character
//   msg_in    message, char 0 in the MSB slice
//   co1       hold counter at terminal value
//   co2       current character is the last one
//   char_out  current character
//   char_idx  index of current character
//   active    message loaded and not yet fully shifted out
module message_datapath
  import message_datapath_pkg::*;
#(
  parameter int unsigned CHAR_W      = DefCharW,
  parameter int unsigned NUM_CHARS   = DefNumChars,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ld,
  input  logic                              cnt1,
  input  logic                              shift,
  input  logic [CHAR_W*NUM_CHARS-1:0]       msg_in,
  output logic                              co1,
  output logic                              co2,
  output logic [CHAR_W-1:0]                 char_out,
  output logic [cnt_width(NUM_CHARS)-1:0]   char_idx,
  output logic                              active
);

  localparam int unsigned MsgW = CHAR_W * NUM_CHARS;
  localparam int unsigned HW   = cnt_width(HOLD_CYCLES);
  localparam int unsigned IW   = cnt_width(NUM_CHARS);

  logic [MsgW-1:0] msg_q, msg_d;
  logic            active_q, active_d;
  logic [HW-1:0]   hold_cnt;

  // Shifting clears the hold count so each new character gets a full hold time.
  mod_counter #(
    .N (HOLD_CYCLES)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ld | shift),
    .en  (cnt1),
    .q   (hold_cnt),
    .tc  (co1)
  );

  mod_counter #(
    .N (NUM_CHARS)
  ) u_char_idx (
    .clk (clk),
    .rst (rst),
    .clr (ld),
    .en  (shift),
    .q   (char_idx),
    .tc  (co2)
  );

  always_comb begin
    msg_d    = msg_q;
    active_d = active_q;
    if (ld) begin
      msg_d    = msg_in;
      active_d = 1'b1;
    end else if (shift) begin
      msg_d = msg_q << CHAR_W;
      if (co2) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q    <= '0;
      active_q <= 1'b0;
    end else begin
      msg_q    <= msg_d;
      active_q <= active_d;
    end
  end

  assign char_out = msg_q[MsgW-1 -: CHAR_W];
  assign active   = active_q;

endmodule

// File: tb/tb_message_datapath.sv
module tb_message_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld, cnt1, shift;
  logic [31:0] msg_in;
  logic        co1, co2, active;
  logic [7:0]  char_out;
  logic [1:0]  char_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] ch;
    logic [1:0] idx;
    logic       act;
    logic       c1;
    logic       c2;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_msg;
  int          m_hold, m_idx;
  logic        m_act;

  message_datapath #(
    .CHAR_W      (8),
    .NUM_CHARS   (4),
    .HOLD_CYCLES (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .cnt1     (cnt1),
    .shift    (shift),
    .msg_in   (msg_in),
    .co1      (co1),
    .co2      (co2),
    .char_out (char_out),
    .char_idx (char_idx),
    .active   (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_msg  = '0;
    m_hold = 0;
    m_idx  = 0;
    m_act  = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.ch  = m_msg[31:24];
    e.idx = 2'(m_idx);
    e.act = m_act;
    e.c1  = (m_hold == 2);
    e.c2  = (m_idx == 3);
    return e;
  endfunction

  task automatic model_step(input logic l, input logic c, input logic s, input logic [31:0] m);
    if (l) begin
      m_msg = m; m_hold = 0; m_idx = 0; m_act = 1'b1;
    end else if (s) begin
      m_msg  = {m_msg[23:0], 8'h00};
      m_hold = 0;
      if (m_idx == 3) begin
        m_idx = 0; m_act = 1'b0;
      end else begin
        m_idx = m_idx + 1;
      end
    end else if (c) begin
      m_hold = (m_hold == 2) ? 0 : m_hold + 1;
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_char"}, 32'(char_out), 32'(e.ch));
      check({tag, "_idx"}, 32'(char_idx), 32'(e.idx));
      check({tag, "_active"}, 32'(active), 32'(e.act));
      check({tag, "_co1"}, 32'(co1), 32'(e.c1));
      check({tag, "_co2"}, 32'(co2), 32'(e.c2));
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare just after the edge.
  task automatic step(input string tag, input logic l, input logic c, input logic s,
                      input logic [31:0] m);
    ld = l; cnt1 = c; shift = s; msg_in = m;
    model_step(l, c, s, m);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    ld = 1'b0; cnt1 = 1'b0; shift = 1'b0;
    compare_pop(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_char"}, 32'(char_out), 32'd0);
    check({tag, "_idx"}, 32'(char_idx), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_co1"}, 32'(co1), 32'd0);
    check({tag, "_co2"}, 32'(co2), 32'd0);
  endtask

  initial begin
    rst = 1'b0; ld = 1'b1; cnt1 = 1'b0; shift = 1'b0; msg_in = 32'h41424344;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_with_ld");
    ld = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset_idle");

    step("load", 1'b1, 1'b0, 1'b0, 32'h41424344);
    check("load_char_const", 32'(char_out), 32'h41);
    step("cnt1_a", 1'b0, 1'b1, 1'b0, '0);
    step("cnt1_b", 1'b0, 1'b1, 1'b0, '0);
    check("co1_terminal", 32'(co1), 32'd1);
    step("cnt1_wrap", 1'b0, 1'b1, 1'b0, '0);
    check("co1_wrap", 32'(co1), 32'd0);

    // Full pass: reload then three holds and a shift per character.
    step("reload", 1'b1, 1'b0, 1'b0, 32'h41424344);
    for (int k = 0; k < 4; k++) begin
      check("seq_char", 32'(char_out), 32'h41 + 32'(k));
      check("seq_co2", 32'(co2), (k == 3) ? 32'd1 : 32'd0);
      for (int h = 0; h < 3; h++) step("seq_hold", 1'b0, 1'b1, 1'b0, '0);
      step("seq_shift", 1'b0, 1'b0, 1'b1, '0);
    end
    check("end_active", 32'(active), 32'd0);
    check("end_idx", 32'(char_idx), 32'd0);
    check("end_char", 32'(char_out), 32'd0);

    // cnt1 and shift together at hold_cnt=1: shift wins, hold restarts.
    step("both_load", 1'b1, 1'b0, 1'b0, 32'h11223344);
    step("both_hold", 1'b0, 1'b1, 1'b0, '0);
    step("both", 1'b0, 1'b1, 1'b1, '0);
    check("both_idx", 32'(char_idx), 32'd1);
    step("both_h1", 1'b0, 1'b1, 1'b0, '0);
    check("both_co1_early", 32'(co1), 32'd0);
    step("both_h2", 1'b0, 1'b1, 1'b0, '0);
    check("both_co1", 32'(co1), 32'd1);

    // Abort by ld at char_idx=2.
    step("abort_shift", 1'b0, 1'b0, 1'b1, '0);
    check("abort_pre_idx", 32'(char_idx), 32'd2);
    step("abort_ld", 1'b1, 1'b0, 1'b0, 32'hAABBCCDD);
    check("abort_char", 32'(char_out), 32'hAA);
    check("abort_idx", 32'(char_idx), 32'd0);

    // Asynchronous reset mid-hold, between clock edges.
    step("ar_hold", 1'b0, 1'b1, 1'b0, '0);
    step("ar_shift", 1'b0, 1'b0, 1'b1, '0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    rst = 1'b1;

    // Shift and count while inactive.
    step("idle_shift", 1'b0, 1'b0, 1'b1, '0);
    step("idle_cnt", 1'b0, 1'b1, 1'b0, '0);

    // Random traffic against the model.
    for (int r = 0; r < 60; r++) begin
      step("rand", ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
